// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: FSM encoding, digit patterns, digit limit.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DROP    = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    // Segment patterns, bit order g f e d c b a (bit6 = g), 1 = lit
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    localparam int MAX_DIGITS_DEF = 4;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to digit lookup; only exact patterns match.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       valid_o
);

    // Exact-match lookup; anything else reports invalid with digit 0
    always_comb begin
        digit_o = 4'd0;
        valid_o = 1'b1;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_decode_accum.sv
// Collects a frame of 7-segment digit beats into packed BCD and binary,
// flags bad patterns / overlong frames, and holds the result until taken.
module seg_decode_accum
    import seg7_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_valid,
    input  logic [6:0]  seg_in,
    input  logic        seg_last,
    output logic        seg_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_bcd,
    output logic [13:0] out_bin,
    output logic [2:0]  out_ndig,
    output logic        out_err
);

    localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

    state_e      state_q;
    logic [15:0] bcd_q,  bcd_d;
    logic [13:0] bin_q,  bin_d;
    logic [2:0]  ndig_q, ndig_d;
    logic        err_q;

    logic [3:0]  digit;
    logic        dig_ok;
    logic        xfer;
    logic        bad_beat;

    seg7_pattern_decode u_dec (
        .seg_i   (seg_in),
        .digit_o (digit),
        .valid_o (dig_ok)
    );

    assign xfer     = seg_valid && seg_ready;
    // A beat is an error if it is not a digit or would exceed the digit limit
    assign bad_beat = !dig_ok || (ndig_q == MAXD);

    // Accumulate candidates; 999*10+9 fits in 14 bits so no truncation
    always_comb begin
        bcd_d  = {bcd_q[11:0], digit};
        bin_d  = 14'(bin_q * 14'd10) + {10'd0, digit};
        ndig_d = ndig_q + 3'd1;
    end

    // Frame FSM; accumulators are zeroed on error so HOLD shows 0 results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (xfer) begin
                        if (bad_beat) begin
                            err_q   <= 1'b1;
                            bcd_q   <= '0;
                            bin_q   <= '0;
                            ndig_q  <= '0;
                            state_q <= seg_last ? S_HOLD : S_DROP;
                        end else begin
                            bcd_q   <= bcd_d;
                            bin_q   <= bin_d;
                            ndig_q  <= ndig_d;
                            state_q <= seg_last ? S_HOLD : S_COLLECT;
                        end
                    end
                end
                S_DROP: begin
                    if (xfer && seg_last) state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        bcd_q   <= '0;
                        bin_q   <= '0;
                        ndig_q  <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign seg_ready = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign out_bcd   = bcd_q;
    assign out_bin   = bin_q;
    assign out_ndig  = ndig_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_seg_decode_accum.sv
// Directed bench for seg_decode_accum with hand-computed expectations.
module tb_seg_decode_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seg_valid;
    logic [6:0]  seg_in;
    logic        seg_last;
    logic        seg_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [13:0] out_bin;
    logic [2:0]  out_ndig;
    logic        out_err;

    int n_chk = 0;
    int n_err = 0;

    seg_decode_accum #(.MAX_DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_valid (seg_valid),
        .seg_in    (seg_in),
        .seg_last  (seg_last),
        .seg_ready (seg_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_bin   (out_bin),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one beat at a negedge, wait for ready, transfer on the next posedge
    task automatic send(input logic [6:0] p, input logic last);
        int n;
        @(negedge clk);
        seg_valid = 1'b1;
        seg_in    = p;
        seg_last  = last;
        n = 0;
        while (!seg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!seg_ready) chk("beat_ready_timeout", {31'd0, seg_ready}, 32'd1);
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        seg_last  = 1'b0;
        seg_in    = 7'h00;
    endtask

    // Sample at the negedge right after the last beat: result must already be up
    task automatic expect_result(input string tag, input logic err, input logic [15:0] bcd,
                                 input logic [13:0] bin, input logic [2:0] nd);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_err"},   {31'd0, out_err},   {31'd0, err});
        chk({tag, "_bcd"},   {16'd0, out_bcd},   {16'd0, bcd});
        chk({tag, "_bin"},   {18'd0, out_bin},   {18'd0, bin});
        chk({tag, "_ndig"},  {29'd0, out_ndig},  {29'd0, nd});
        chk({tag, "_ready"}, {31'd0, seg_ready}, 32'd0);
    endtask

    // Handshake the result and confirm return to idle
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_clr"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_set"}, {31'd0, seg_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        seg_valid = 1'b0;
        seg_in    = 7'h00;
        seg_last  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err",   {31'd0, out_err},   32'd0);
        chk("rst_bcd",   {16'd0, out_bcd},   32'd0);
        chk("rst_bin",   {18'd0, out_bin},   32'd0);
        chk("rst_ndig",  {29'd0, out_ndig},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, seg_ready}, 32'd1);

        // 3, 2, 6 -> 326
        send(7'h4F, 1'b0);
        send(7'h5B, 1'b0);
        send(7'h7D, 1'b1);
        expect_result("f326", 1'b0, 16'h0326, 14'd326, 3'd3);
        consume("f326");

        // invalid middle beat, following beat dropped
        send(7'h06, 1'b0);
        send(7'h00, 1'b0);
        send(7'h3F, 1'b1);
        expect_result("fbad", 1'b1, 16'h0000, 14'd0, 3'd0);
        consume("fbad");

        // five digits overflow the limit of four
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b1);
        expect_result("fovf", 1'b1, 16'h0000, 14'd0, 3'd0);
        consume("fovf");
        send(7'h07, 1'b1);
        expect_result("f7", 1'b0, 16'h0007, 14'd7, 3'd1);
        consume("f7");

        // result held under backpressure, beats refused meanwhile
        send(7'h7F, 1'b1);
        expect_result("f8", 1'b0, 16'h0008, 14'd8, 3'd1);
        seg_valid = 1'b1;
        seg_in    = 7'h06;
        seg_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_bcd",   {16'd0, out_bcd},   32'h0008);
            chk("hold_ready", {31'd0, seg_ready}, 32'd0);
        end
        seg_valid = 1'b0;
        seg_last  = 1'b0;
        consume("f8");
        chk("f8_no_extra", {31'd0, out_valid}, 32'd0);

        // invalid pattern on the last beat goes straight to an error result
        send(7'h01, 1'b1);
        expect_result("flast_bad", 1'b1, 16'h0000, 14'd0, 3'd0);
        consume("flast_bad");

        // reset mid-frame discards partial digits
        send(7'h66, 1'b0);
        send(7'h6D, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_ndig", {29'd0, out_ndig}, 32'd0);
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        send(7'h3F, 1'b1);
        expect_result("f0", 1'b0, 16'h0000, 14'd0, 3'd1);
        consume("f0");

        // full four-digit maximum
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b0);
        send(7'h6F, 1'b1);
        expect_result("f9999", 1'b0, 16'h9999, 14'd9999, 3'd4);

        // reset while holding drops the pending result
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hold_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_rst_bin",   {18'd0, out_bin},   32'd0);
        chk("hold_rst_ready", {31'd0, seg_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
